internal_ram_axi_ctrl: RTL
==========================

Name: internal_ram_axi_ctrl

Overview:
AXI-style burst slave controller that sequences the 4096x32 on-chip RAM macro (Ram_1wrs: en/wr/addr/mask/wrData in, rdData out one cycle after en). It accepts one combined read/write address channel, expands INCR/WRAP/FIXED bursts into per-word RAM accesses, and returns read data through a 2-entry buffer so R-channel backpressure never loses data. It sits between the interconnect and the RAM macro.

Parameters:
ADDR_BITS, 14, byte-address width on the AXI side; word address = addr[13:2]
RD_BUF_DEPTH, 2, read-return buffer entries (fixed at 2; needed for full throughput)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
axi_arw_valid  in  1  address request valid
axi_arw_ready  out  1  address accepted
axi_arw_payload_addr  in  ADDR_BITS  byte address
axi_arw_payload_id  in  1  transaction id
axi_arw_payload_len  in  8  beats-1
axi_arw_payload_size  in  3  must be 2; other values treated as 2
axi_arw_payload_burst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 treated as INCR
axi_arw_payload_write  in  1  1 = write burst
axi_w_valid / axi_w_ready  in/out  1  write beat handshake
axi_w_payload_data  in  32  write data
axi_w_payload_strb  in  4  byte enables
axi_w_payload_last  in  1  ignored for termination
axi_b_valid / axi_b_ready  out/in  1  write response handshake
axi_b_payload_id  out  1  latched id
axi_b_payload_resp  out  2  response code
axi_r_valid / axi_r_ready  out/in  1  read beat handshake
axi_r_payload_data  out  32  read data
axi_r_payload_id  out  1  latched id
axi_r_payload_last  out  1  final beat
ram_en  out  1  RAM clock enable
ram_wr  out  1  RAM write
ram_addr  out  12  RAM word address
ram_mask  out  4  byte mask
ram_wrData  out  32  RAM write data
ram_rdData  in  32  RAM read data, valid cycle after ram_en

Behaviour:
- One clock (clk); reset synchronous, active-high. On reset: state IDLE; axi_arw_ready=1; axi_r_valid, axi_b_valid, ram_en, ram_wr = 0; read buffer and in-flight count cleared; axi_b_payload_resp=0. Reset mid-burst abandons the burst with no further responses.
- States: IDLE, READ, WRITE, WRESP. axi_arw_ready=1 only in IDLE. Handshake latches word address, id, len, burst type, and beat counter=0. Next state is READ or WRITE by payload_write.
- Address step after each issued beat: FIXED holds. INCR adds 1 modulo 4096. WRAP uses mask=len; next=(a & ~mask)|((a+1) & mask). len must be 1, 3, 7 or 15; other values behave as INCR.
- READ: issue (ram_en=1, ram_wr=0, ram_mask=4'hF) in any cycle where occupancy+in_flight<2 and issued beats<=len. Data captured into buffer on the cycle after issue. axi_r_valid=buffer non-empty; payload_last=1 on beat index len. With arw handshake in cycle 0 and r_ready=1: ram_en in cycle 1, r_valid from cycle 3, one beat per cycle. Return to IDLE on the cycle after the last beat's r handshake.
- WRITE: axi_w_ready=1. Each w handshake drives ram_en=ram_wr=1 in the same cycle, combinationally, with ram_mask=strb, ram_wrData=data and ram_addr=current. After beat len go to WRESP; axi_b_valid=1 and resp=2'b00 until b_ready, then IDLE.
- ram_en is never asserted outside an issue or w beat. Simultaneous buffer push and pop keep occupancy.

Optional Feature:
BOOTROM_PROTECT_EN: when defined, write beats to word addresses 0..1023 drive ram_en=1 and ram_wr=0. Any such beat in a burst sets axi_b_payload_resp=2'b10 (SLVERR). When undefined, every write is performed and resp is always 2'b00. RAM-internal protection stays in place regardless.

Test Plan:
- Write 0xDEADBEEF to byte addr 0x1000 with strb 4'hF, then read len=0 -> r_data 0xDEADBEEF, last=1, id echoed, b resp 0.
- INCR read len=3 at 0x1000, r_ready toggled 1/0 each cycle -> 4 beats in order, no loss, ram_en never asserted with 2 beats pending.
- WRAP read len=3 at 0x1008 -> ram_addr sequence 0x402, 0x403, 0x400, 0x401.
- Write strb 4'b0011 data 0x11223344 over 0xAAAAAAAA -> readback merges only the enabled bytes.
- Reset asserted on beat 2 of an 8-beat read -> next cycle r_valid=0 and arw_ready=1.
- With BOOTROM_PROTECT_EN, write to 0x0100 -> ram_wr=0 and b resp 2'b10; without the macro -> ram_wr=1 and resp 2'b00.

Source files
------------

// File: rtl/internal_ram_axi_ctrl.sv
// internal_ram_axi_ctrl
// AXI-style burst slave in front of the 4096x32 single-port RAM macro.
// One combined read/write address channel; INCR/WRAP/FIXED bursts are expanded
// into per-word RAM accesses. Read data returns through a 2-entry buffer so
// R-channel backpressure never drops a beat.
// Optional build macro: BOOTROM_PROTECT_EN -- when defined, write beats aimed at
// word addresses 0..1023 are turned into harmless reads and the burst answers
// SLVERR on the B channel.
module internal_ram_axi_ctrl #(
  parameter int ADDR_BITS    = 14,
  parameter int RD_BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 axi_arw_valid,
  output logic                 axi_arw_ready,
  input  logic [ADDR_BITS-1:0] axi_arw_payload_addr,
  input  logic                 axi_arw_payload_id,
  input  logic [7:0]           axi_arw_payload_len,
  input  logic [2:0]           axi_arw_payload_size,
  input  logic [1:0]           axi_arw_payload_burst,
  input  logic                 axi_arw_payload_write,
  input  logic                 axi_w_valid,
  output logic                 axi_w_ready,
  input  logic [31:0]          axi_w_payload_data,
  input  logic [3:0]           axi_w_payload_strb,
  input  logic                 axi_w_payload_last,
  output logic                 axi_b_valid,
  input  logic                 axi_b_ready,
  output logic                 axi_b_payload_id,
  output logic [1:0]           axi_b_payload_resp,
  output logic                 axi_r_valid,
  input  logic                 axi_r_ready,
  output logic [31:0]          axi_r_payload_data,
  output logic                 axi_r_payload_id,
  output logic                 axi_r_payload_last,
  output logic                 ram_en,
  output logic                 ram_wr,
  output logic [11:0]          ram_addr,
  output logic [3:0]           ram_mask,
  output logic [31:0]          ram_wrData,
  input  logic [31:0]          ram_rdData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_t;

  // Size is always treated as 4 bytes, W.last is not used for termination and
  // the byte offset inside a word is irrelevant to the word-wide RAM.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, axi_arw_payload_size, axi_w_payload_last,
                           axi_arw_payload_addr};

  state_t      state_reg, state_next;
  logic [11:0] addr_reg;
  logic [11:0] addr_next;
  logic        id_reg;
  logic [7:0]  len_reg;
  logic [1:0]  burst_reg;
  logic [8:0]  beat_cnt_reg;      // beats issued (read) or accepted (write)

  // Read return path: one RAM access may be in flight, then it lands in the buffer.
  logic        inflight_reg;
  logic        inflight_last_reg;
  logic [1:0]  occ_reg;
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [31:0] buf_data [0:RD_BUF_DEPTH-1];
  logic        buf_last [0:RD_BUF_DEPTH-1];

  logic        arw_fire;
  logic        w_fire;
  logic        r_fire;
  logic        issue;
  logic        beat_step;
  logic        wr_blocked;
  logic [2:0]  fill_after_pop;
  logic        wrap_ok;
  logic [11:0] wrap_mask;
  logic [11:0] addr_inc;

  assign arw_fire  = (state_reg == IDLE) && axi_arw_valid;
  assign w_fire    = (state_reg == WRITE) && axi_w_valid;
  assign r_fire    = axi_r_valid && axi_r_ready;
  assign beat_step = issue || w_fire;

  // A beat leaving the buffer this cycle frees its slot in time for a new issue,
  // which is what lets a 2-entry buffer sustain one beat per cycle.
  assign fill_after_pop = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, r_fire};
  assign issue = (state_reg == READ) && (fill_after_pop < 3'(RD_BUF_DEPTH)) &&
                 (beat_cnt_reg <= {1'b0, len_reg});

  assign axi_r_valid        = (occ_reg != 2'd0);
  assign axi_r_payload_data = buf_data[rd_ptr_reg];
  assign axi_r_payload_last = buf_last[rd_ptr_reg];
  assign axi_r_payload_id   = id_reg;
  assign axi_b_payload_id   = id_reg;

`ifdef BOOTROM_PROTECT_EN
  logic err_reg;
  assign wr_blocked         = (addr_reg[11:10] == 2'b00);
  assign axi_b_payload_resp = err_reg ? 2'b10 : 2'b00;

  // Remember whether any beat of the current write burst hit the boot ROM window.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (arw_fire) begin
      err_reg <= 1'b0;
    end else if (w_fire && wr_blocked) begin
      err_reg <= 1'b1;
    end
  end
`else
  assign wr_blocked         = 1'b0;
  assign axi_b_payload_resp = 2'b00;
`endif

  // Next word address after a beat: FIXED holds, WRAP stays inside its aligned
  // window (only for 2/4/8/16-beat bursts), everything else increments mod 4096.
  always_comb begin
    wrap_ok   = (len_reg == 8'd1) || (len_reg == 8'd3) ||
                (len_reg == 8'd7) || (len_reg == 8'd15);
    wrap_mask = {8'h00, len_reg[3:0]};
    addr_inc  = addr_reg + 12'd1;
    case (burst_reg)
      2'd0:    addr_next = addr_reg;
      2'd2:    addr_next = wrap_ok ? ((addr_reg & ~wrap_mask) | (addr_inc & wrap_mask))
                                   : addr_inc;
      default: addr_next = addr_inc;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the handshake / RAM control outputs.
  always_comb begin
    state_next    = state_reg;
    axi_arw_ready = 1'b0;
    axi_w_ready   = 1'b0;
    axi_b_valid   = 1'b0;
    ram_en        = 1'b0;
    ram_wr        = 1'b0;
    ram_addr      = addr_reg;
    ram_mask      = 4'h0;
    ram_wrData    = 32'h0;
    case (state_reg)
      IDLE: begin
        axi_arw_ready = 1'b1;
        if (axi_arw_valid) begin
          state_next = axi_arw_payload_write ? WRITE : READ;
        end
      end
      READ: begin
        if (issue) begin
          ram_en   = 1'b1;
          ram_mask = 4'hF;
        end
        if (r_fire && axi_r_payload_last) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        axi_w_ready = 1'b1;
        if (axi_w_valid) begin
          ram_en     = 1'b1;
          ram_wr     = !wr_blocked;
          ram_mask   = axi_w_payload_strb;
          ram_wrData = axi_w_payload_data;
          if (beat_cnt_reg == {1'b0, len_reg}) begin
            state_next = WRESP;
          end
        end
      end
      WRESP: begin
        axi_b_valid = 1'b1;
        if (axi_b_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst context: latched on the address handshake, advanced once per beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg     <= 12'h000;
      id_reg       <= 1'b0;
      len_reg      <= 8'h00;
      burst_reg    <= 2'd0;
      beat_cnt_reg <= 9'd0;
    end else if (arw_fire) begin
      addr_reg     <= axi_arw_payload_addr[13:2];
      id_reg       <= axi_arw_payload_id;
      len_reg      <= axi_arw_payload_len;
      burst_reg    <= axi_arw_payload_burst;
      beat_cnt_reg <= 9'd0;
    end else if (beat_step) begin
      addr_reg     <= addr_next;
      beat_cnt_reg <= beat_cnt_reg + 9'd1;
    end
  end

  // Track the read issued last cycle; its data appears on ram_rdData now.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= (beat_cnt_reg == {1'b0, len_reg});
    end
  end

  // Return buffer bookkeeping: push on RAM data arrival, pop on R handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg    <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (inflight_reg) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (r_fire) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({inflight_reg, r_fire})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Return buffer storage; contents are only meaningful while counted in occ_reg.
  always_ff @(posedge clk) begin
    if (inflight_reg) begin
      buf_data[wr_ptr_reg] <= ram_rdData;
      buf_last[wr_ptr_reg] <= inflight_last_reg;
    end
  end

endmodule
